// File: rtl/cpu_pkg.sv
// Shared RV32 core definitions: widths, the canonical NOP, fetch states and the
// opcode/funct3 encodings that fetch and decode agree on.
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_ADD  = 3'b000;

endpackage

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch stage: owns the PC, one outstanding imem read.
// Optional FETCH_PERF_EN adds handshake and stall counters.
module fetch_unit #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_out,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  import cpu_pkg::*;

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            kill, kill_n;
  logic            instr_valid_n;
  logic [XLEN-1:0] instr_n, pc_out_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      kill           <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_addr      <= RESET_PC;
      instr_valid    <= 1'b0;
      instr          <= XLEN'(NOP_INSTR);
      pc_out         <= '0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      kill           <= kill_n;
      imem_req_valid <= (state_n == REQ);
      imem_addr      <= pc_n;
      instr_valid    <= instr_valid_n;
      instr          <= instr_n;
      pc_out         <= pc_out_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    kill_n        = kill;
    instr_valid_n = instr_valid;
    instr_n       = instr;
    pc_out_n      = pc_out;

    case (state)
      BOOT: state_n = REQ;
      REQ:  if (imem_req_ready) state_n = WAIT;
      WAIT: begin
        if (imem_rsp_valid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = REQ;
          end else begin
            instr_n       = imem_rsp_data;
            pc_out_n      = pc;
            instr_valid_n = 1'b1;
            pc_n          = pc + XLEN'(INSTR_BYTES);
            state_n       = HOLD;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          instr_valid_n = 1'b0;
          state_n       = REQ;
        end
      end
      default: state_n = BOOT;
    endcase

    // A redirect overrides everything; an already-accepted request must be killed
    if (redirect_valid) begin
      pc_n          = {redirect_pc[XLEN-1:2], 2'b00};
      instr_valid_n = 1'b0;
      instr_n       = instr;
      pc_out_n      = pc_out;
      case (state)
        REQ: begin
          if (imem_req_ready) begin
            kill_n  = 1'b1;
            state_n = WAIT;
          end else begin
            state_n = REQ;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            kill_n  = 1'b0;
            state_n = REQ;
          end else begin
            kill_n  = 1'b1;
            state_n = WAIT;
          end
        end
        default: state_n = REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (instr_valid && instr_ready)
        perf_fetched <= perf_fetched + 32'd1;
      if ((state == REQ && !imem_req_ready) || (state == WAIT && !imem_rsp_valid))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
